// File: rtl/ctrl_pipe_if.sv
// Bundle of decode inputs, hazard controls and per-stage control outputs
// exchanged between the datapath/hazard unit (master) and ctrl_pipe (slave).
interface ctrl_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ALUCTRL_W  = 4,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] instr_D;
    logic                  valid_D;
    logic                  stall_E;
    logic                  flush_E;

    logic                  branch_D;
    logic                  jump_D;
    logic                  illegal_D;
    logic [2:0]            immsel_D;

    logic                  alusrc_E;
    logic                  aluasrc_E;
    logic [ALUCTRL_W-1:0]  alucontrol_E;
    logic                  memread_E;
    logic                  valid_E;

    logic                  memread_M;
    logic                  memwrite_M;
    logic                  regwrite_M;
    logic                  valid_M;

    logic                  regwrite_W;
    logic [1:0]            regsrc_W;
    logic                  valid_W;

    logic [CNT_WIDTH-1:0]  instret;

    modport master (
        output instr_D, valid_D, stall_E, flush_E,
        input  branch_D, jump_D, illegal_D, immsel_D,
        input  alusrc_E, aluasrc_E, alucontrol_E, memread_E, valid_E,
        input  memread_M, memwrite_M, regwrite_M, valid_M,
        input  regwrite_W, regsrc_W, valid_W, instret
    );

    modport slave (
        input  instr_D, valid_D, stall_E, flush_E,
        output branch_D, jump_D, illegal_D, immsel_D,
        output alusrc_E, aluasrc_E, alucontrol_E, memread_E, valid_E,
        output memread_M, memwrite_M, regwrite_M, valid_M,
        output regwrite_W, regsrc_W, valid_W, instret
    );
endinterface

// File: rtl/ctrl_pipe.sv
// RV32I pipelined control unit: combinational D-stage decode feeding
// E/M/W control registers with stall/flush at D->E and a retire counter.
module ctrl_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ALUCTRL_W  = 4,
    parameter bit EN_MUL     = 1'b0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);
    localparam logic [3:0] ALU_NONE  = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_MUL   = 4'b1011;
    localparam logic [3:0] ALU_PASSB = 4'b1100;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       aluasrc;
        logic [1:0] regsrc;
        logic [3:0] alu;
        logic       branch;
        logic       jump;
        logic [2:0] immsel;
    } dec_t;

    logic [DATA_WIDTH-1:0] instr;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  unused_instr;
    dec_t                  raw;
    dec_t                  dec;
    logic                  illegal;
    logic                  load_d;

    logic                  alusrc_e;
    logic                  aluasrc_e;
    logic [ALUCTRL_W-1:0]  alu_e;
    logic                  memread_e;
    logic                  memwrite_e;
    logic                  regwrite_e;
    logic [1:0]            regsrc_e;
    logic                  valid_e;

    logic                  memread_m;
    logic                  memwrite_m;
    logic                  regwrite_m;
    logic [1:0]            regsrc_m;
    logic                  valid_m;

    logic                  regwrite_w;
    logic [1:0]            regsrc_w;
    logic                  valid_w;
    logic [CNT_WIDTH-1:0]  instret;

    assign instr        = bus.instr_D;
    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^instr;

    // Shared funct3 -> ALU mapping for register and immediate arithmetic.
    function automatic logic [3:0] alu_by_funct3(input logic [2:0] f3, input logic arith);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return arith ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (opcode)
            7'h33: begin
                raw.regwrite = 1'b1;
                if (funct7 == 7'h00)
                    raw.alu = alu_by_funct3(funct3, 1'b0);
                else if (funct7 == 7'h20 && funct3 == 3'b000)
                    raw.alu = ALU_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'b101)
                    raw.alu = ALU_SRA;
                else if (funct7 == 7'h01 && funct3 == 3'b000 && EN_MUL)
                    raw.alu = ALU_MUL;
                else
                    illegal = 1'b1;
            end
            7'h13: begin
                raw.alu      = alu_by_funct3(funct3, instr[30]);
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.immsel   = 3'b001;
            end
            7'h03: begin
                raw.alu      = ALU_ADD;
                raw.alusrc   = 1'b1;
                raw.memread  = 1'b1;
                raw.regwrite = 1'b1;
                raw.regsrc   = 2'b01;
                raw.immsel   = 3'b001;
            end
            7'h23: begin
                raw.alu      = ALU_ADD;
                raw.alusrc   = 1'b1;
                raw.memwrite = 1'b1;
                raw.immsel   = 3'b010;
            end
            7'h63: begin
                raw.alu    = ALU_SUB;
                raw.branch = 1'b1;
                raw.immsel = 3'b011;
            end
            7'h6F: begin
                raw.jump     = 1'b1;
                raw.regwrite = 1'b1;
                raw.regsrc   = 2'b10;
                raw.immsel   = 3'b101;
            end
            7'h67: begin
                raw.jump     = 1'b1;
                raw.alu      = ALU_ADD;
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.regsrc   = 2'b10;
                raw.immsel   = 3'b001;
            end
            7'h37: begin
                raw.alu      = ALU_PASSB;
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.immsel   = 3'b100;
            end
            7'h17: begin
                raw.alu      = ALU_ADD;
                raw.alusrc   = 1'b1;
                raw.aluasrc  = 1'b1;
                raw.regwrite = 1'b1;
                raw.immsel   = 3'b100;
            end
            default: illegal = 1'b1;
        endcase
        dec = illegal ? '0 : raw;
        if (ALU_NONE != 4'b0000)
            dec = '0;
    end

    assign load_d = bus.valid_D & ~illegal;

    // A held (stalled) E word must not also advance, so M takes a bubble
    // instead; a flush releases the E word into M while E itself empties.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alusrc_e   <= 1'b0;
            aluasrc_e  <= 1'b0;
            alu_e      <= '0;
            memread_e  <= 1'b0;
            memwrite_e <= 1'b0;
            regwrite_e <= 1'b0;
            regsrc_e   <= 2'b00;
            valid_e    <= 1'b0;
            memread_m  <= 1'b0;
            memwrite_m <= 1'b0;
            regwrite_m <= 1'b0;
            regsrc_m   <= 2'b00;
            valid_m    <= 1'b0;
            regwrite_w <= 1'b0;
            regsrc_w   <= 2'b00;
            valid_w    <= 1'b0;
            instret    <= '0;
        end else begin
            if (valid_w)
                instret <= instret + CNT_WIDTH'(1);

            regwrite_w <= regwrite_m;
            regsrc_w   <= regsrc_m;
            valid_w    <= valid_m;

            if (bus.stall_E && !bus.flush_E) begin
                memread_m  <= 1'b0;
                memwrite_m <= 1'b0;
                regwrite_m <= 1'b0;
                regsrc_m   <= 2'b00;
                valid_m    <= 1'b0;
            end else begin
                memread_m  <= memread_e;
                memwrite_m <= memwrite_e;
                regwrite_m <= regwrite_e;
                regsrc_m   <= regsrc_e;
                valid_m    <= valid_e;
            end

            if (bus.flush_E) begin
                alusrc_e   <= 1'b0;
                aluasrc_e  <= 1'b0;
                alu_e      <= '0;
                memread_e  <= 1'b0;
                memwrite_e <= 1'b0;
                regwrite_e <= 1'b0;
                regsrc_e   <= 2'b00;
                valid_e    <= 1'b0;
            end else if (!bus.stall_E) begin
                alusrc_e   <= load_d & dec.alusrc;
                aluasrc_e  <= load_d & dec.aluasrc;
                alu_e      <= load_d ? ALUCTRL_W'(dec.alu) : '0;
                memread_e  <= load_d & dec.memread;
                memwrite_e <= load_d & dec.memwrite;
                regwrite_e <= load_d & dec.regwrite;
                regsrc_e   <= load_d ? dec.regsrc : 2'b00;
                valid_e    <= load_d;
            end
        end
    end

    assign bus.branch_D     = dec.branch;
    assign bus.jump_D       = dec.jump;
    assign bus.illegal_D    = illegal;
    assign bus.immsel_D     = dec.immsel;
    assign bus.alusrc_E     = alusrc_e;
    assign bus.aluasrc_E    = aluasrc_e;
    assign bus.alucontrol_E = alu_e;
    assign bus.memread_E    = memread_e;
    assign bus.valid_E      = valid_e;
    assign bus.memread_M    = memread_m;
    assign bus.memwrite_M   = memwrite_m;
    assign bus.regwrite_M   = regwrite_m;
    assign bus.valid_M      = valid_m;
    assign bus.regwrite_W   = regwrite_w;
    assign bus.regsrc_W     = regsrc_w;
    assign bus.valid_W      = valid_w;
    assign bus.instret      = instret;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (no MUL / 32-bit counter, and MUL /
// 6-bit alucontrol / 4-bit counter) share one stimulus stream.
module tb_ctrl_pipe;
    typedef struct packed {
        logic       illegal, branch, jump;
        logic [2:0] immsel;
        logic       alusrc, aluasrc;
        logic [3:0] alu;
        logic       memread, memwrite, regwrite;
        logic [1:0] regsrc;
    } ref_t;

    typedef struct packed {
        logic       valid, alusrc, aluasrc;
        logic [3:0] alu;
        logic       memread, memwrite, regwrite;
        logic [1:0] regsrc;
    } pw_t;

    typedef struct packed {
        logic        illegal, branch, jump;
        logic [2:0]  immsel;
        logic        alusrc_e, aluasrc_e;
        logic [7:0]  alu_e;
        logic        memread_e, valid_e;
        logic        memread_m, memwrite_m, regwrite_m, valid_m;
        logic        regwrite_w;
        logic [1:0]  regsrc_w;
        logic        valid_w;
        logic [31:0] instret;
    } obs_t;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_LW   = 32'h0000A083;
    localparam logic [31:0] I_ADDI = 32'h40008093;
    localparam logic [31:0] I_SRAI = 32'h4010D093;
    localparam logic [31:0] I_MUL  = 32'h022080B3;
    localparam logic [31:0] I_JAL  = 32'h008000EF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        valid_D, stall_E, flush_E;

    int checks = 0;
    int errors = 0;

    pw_t         e_m [2];
    pw_t         m_m [2];
    pw_t         w_m [2];
    int unsigned cnt [2];
    obs_t        obs [2];

    always #5 clk = ~clk;

    ctrl_pipe_if #(.DATA_WIDTH(32), .ALUCTRL_W(4), .CNT_WIDTH(32)) if_a ();
    ctrl_pipe_if #(.DATA_WIDTH(32), .ALUCTRL_W(6), .CNT_WIDTH(4))  if_b ();

    assign if_a.instr_D = instr;
    assign if_a.valid_D = valid_D;
    assign if_a.stall_E = stall_E;
    assign if_a.flush_E = flush_E;
    assign if_b.instr_D = instr;
    assign if_b.valid_D = valid_D;
    assign if_b.stall_E = stall_E;
    assign if_b.flush_E = flush_E;

    ctrl_pipe #(.DATA_WIDTH(32), .ALUCTRL_W(4), .EN_MUL(1'b0), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    ctrl_pipe #(.DATA_WIDTH(32), .ALUCTRL_W(6), .EN_MUL(1'b1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));

    assign obs[0] = {if_a.illegal_D, if_a.branch_D, if_a.jump_D, if_a.immsel_D,
                     if_a.alusrc_E, if_a.aluasrc_E, {4'b0000, if_a.alucontrol_E},
                     if_a.memread_E, if_a.valid_E,
                     if_a.memread_M, if_a.memwrite_M, if_a.regwrite_M, if_a.valid_M,
                     if_a.regwrite_W, if_a.regsrc_W, if_a.valid_W, if_a.instret};
    assign obs[1] = {if_b.illegal_D, if_b.branch_D, if_b.jump_D, if_b.immsel_D,
                     if_b.alusrc_E, if_b.aluasrc_E, {2'b00, if_b.alucontrol_E},
                     if_b.memread_E, if_b.valid_E,
                     if_b.memread_M, if_b.memwrite_M, if_b.regwrite_M, if_b.valid_M,
                     if_b.regwrite_W, if_b.regsrc_W, if_b.valid_W, {28'h0, if_b.instret}};

    // Reference decode written straight from the opcode table.
    function automatic ref_t ref_decode(input logic [31:0] ins, input bit en_mul);
        ref_t       r;
        logic [3:0] tab [8];
        logic [2:0] f3;
        logic [6:0] f7;
        tab = '{4'd1, 4'd6, 4'd9, 4'd10, 4'd5, 4'd7, 4'd4, 4'd3};
        f3  = ins[14:12];
        f7  = ins[31:25];
        r   = '0;
        case (ins[6:0])
            7'h33: begin
                r.regwrite = 1'b1;
                if (f7 == 7'h00)                              r.alu = tab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0)           r.alu = 4'd2;
                else if (f7 == 7'h20 && f3 == 3'd5)           r.alu = 4'd8;
                else if (f7 == 7'h01 && f3 == 3'd0 && en_mul) r.alu = 4'd11;
                else                                          r.illegal = 1'b1;
            end
            7'h13: begin
                r.alu = (f3 == 3'd5 && ins[30]) ? 4'd8 : tab[f3];
                r.alusrc = 1'b1; r.regwrite = 1'b1; r.immsel = 3'd1;
            end
            7'h03: begin
                r.alu = 4'd1; r.alusrc = 1'b1; r.memread = 1'b1;
                r.regwrite = 1'b1; r.regsrc = 2'd1; r.immsel = 3'd1;
            end
            7'h23: begin r.alu = 4'd1; r.alusrc = 1'b1; r.memwrite = 1'b1; r.immsel = 3'd2; end
            7'h63: begin r.alu = 4'd2; r.branch = 1'b1; r.immsel = 3'd3; end
            7'h6F: begin r.jump = 1'b1; r.regwrite = 1'b1; r.regsrc = 2'd2; r.immsel = 3'd5; end
            7'h67: begin
                r.jump = 1'b1; r.alu = 4'd1; r.alusrc = 1'b1;
                r.regwrite = 1'b1; r.regsrc = 2'd2; r.immsel = 3'd1;
            end
            7'h37: begin r.alu = 4'd12; r.alusrc = 1'b1; r.regwrite = 1'b1; r.immsel = 3'd4; end
            7'h17: begin
                r.alu = 4'd1; r.alusrc = 1'b1; r.aluasrc = 1'b1; r.regwrite = 1'b1; r.immsel = 3'd4;
            end
            default: r.illegal = 1'b1;
        endcase
        if (r.illegal) begin
            r = '0;
            r.illegal = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:  begin r[6:0] = 7'h33; r[31:25] = 7'h00; end
            1:  begin r[6:0] = 7'h33; r[31:25] = 7'h20; end
            2:  begin
                    r[6:0] = 7'h33; r[31:25] = 7'h01;
                    if ($urandom_range(0, 1) == 0) r[14:12] = 3'b000;
                end
            3:  r[6:0] = 7'h33;
            4:  r[6:0] = 7'h13;
            5:  r[6:0] = 7'h03;
            6:  r[6:0] = 7'h23;
            7:  r[6:0] = 7'h63;
            8:  r[6:0] = 7'h6F;
            9:  r[6:0] = 7'h67;
            10: r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Instruction-level pipeline model: an instruction leaves E only when
    // E is not held; a flush empties E, a reset empties everything.
    task automatic model_edge(input logic [31:0] ins, input logic vd, st, fl, rs);
        ref_t r;
        for (int d = 0; d < 2; d++) begin
            if (!rs) begin
                e_m[d] = '0; m_m[d] = '0; w_m[d] = '0; cnt[d] = 0;
            end else begin
                if (w_m[d].valid) cnt[d] = cnt[d] + 1;
                w_m[d] = m_m[d];
                m_m[d] = (st && !fl) ? '0 : e_m[d];
                if (fl) e_m[d] = '0;
                else if (!st) begin
                    r = ref_decode(ins, d == 1);
                    e_m[d] = '0;
                    if (vd && !r.illegal)
                        e_m[d] = {1'b1, r.alusrc, r.aluasrc, r.alu, r.memread,
                                  r.memwrite, r.regwrite, r.regsrc};
                end
            end
        end
    endtask

    task automatic check_output();
        string nm;
        for (int d = 0; d < 2; d++) begin
            nm = (d == 0) ? "a" : "b";
            check({nm, ".alusrc_E"},     obs[d].alusrc_e,   e_m[d].alusrc);
            check({nm, ".aluasrc_E"},    obs[d].aluasrc_e,  e_m[d].aluasrc);
            check({nm, ".alucontrol_E"}, obs[d].alu_e,      e_m[d].alu);
            check({nm, ".memread_E"},    obs[d].memread_e,  e_m[d].memread);
            check({nm, ".valid_E"},      obs[d].valid_e,    e_m[d].valid);
            check({nm, ".memread_M"},    obs[d].memread_m,  m_m[d].memread);
            check({nm, ".memwrite_M"},   obs[d].memwrite_m, m_m[d].memwrite);
            check({nm, ".regwrite_M"},   obs[d].regwrite_m, m_m[d].regwrite);
            check({nm, ".valid_M"},      obs[d].valid_m,    m_m[d].valid);
            check({nm, ".regwrite_W"},   obs[d].regwrite_w, w_m[d].regwrite);
            check({nm, ".regsrc_W"},     obs[d].regsrc_w,   w_m[d].regsrc);
            check({nm, ".valid_W"},      obs[d].valid_w,    w_m[d].valid);
            check({nm, ".instret"},      obs[d].instret,    (d == 0) ? cnt[d] : (cnt[d] % 16));
        end
    endtask

    // One clock: drive inputs, check decode, take the edge, check registers.
    task automatic apply_stimulus(input logic [31:0] ins, input logic vd, st, fl, rs);
        ref_t r;
        instr = ins; valid_D = vd; stall_E = st; flush_E = fl; rst = rs;
        #1;
        for (int d = 0; d < 2; d++) begin
            r = ref_decode(ins, d == 1);
            check((d == 0) ? "a.illegal_D" : "b.illegal_D", obs[d].illegal, r.illegal);
            check((d == 0) ? "a.branch_D"  : "b.branch_D",  obs[d].branch,  r.branch);
            check((d == 0) ? "a.jump_D"    : "b.jump_D",    obs[d].jump,    r.jump);
            check((d == 0) ? "a.immsel_D"  : "b.immsel_D",  obs[d].immsel,  r.immsel);
        end
        @(posedge clk);
        model_edge(ins, vd, st, fl, rs);
        #1;
        check_output();
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            e_m[d] = '0; m_m[d] = '0; w_m[d] = '0; cnt[d] = 0;
        end

        apply_stimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(I_LW, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_valid_E", obs[0].valid_e, 0);
        check("rst_valid_M", obs[0].valid_m, 0);
        check("rst_valid_W", obs[0].valid_w, 0);
        check("rst_alu_E", obs[0].alu_e, 0);
        check("rst_instret", obs[0].instret, 0);

        apply_stimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        check("add_alu_E", obs[0].alu_e, 1);
        apply_stimulus(I_LW, 1'b1, 1'b0, 1'b0, 1'b1);
        check("lw_memread_E", obs[0].memread_e, 1);
        bubbles(1);
        check("add_regwrite_W", obs[0].regwrite_w, 1);
        check("add_regsrc_W", obs[0].regsrc_w, 0);
        bubbles(1);
        check("lw_regsrc_W", obs[0].regsrc_w, 1);
        check("instret_after4", obs[0].instret, 1);
        bubbles(1);
        check("instret_after5", obs[0].instret, 2);

        apply_stimulus(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b1);
        check("addi_alu_E", obs[0].alu_e, 1);
        apply_stimulus(I_SRAI, 1'b1, 1'b0, 1'b0, 1'b1);
        check("srai_alu_E", obs[0].alu_e, 8);
        bubbles(4);
        check("instret_addi", obs[0].instret, 4);

        apply_stimulus(I_MUL, 1'b1, 1'b0, 1'b0, 1'b1);
        check("mul0_illegal_D", obs[0].illegal, 1);
        check("mul1_illegal_D", obs[1].illegal, 0);
        check("mul0_valid_E", obs[0].valid_e, 0);
        check("mul1_valid_E", obs[1].valid_e, 1);
        check("mul1_alu_E", obs[1].alu_e, 11);
        bubbles(4);
        check("mul0_instret", obs[0].instret, 4);
        check("mul1_instret", obs[1].instret, 5);

        apply_stimulus(I_JAL, 1'b1, 1'b0, 1'b0, 1'b1);
        check("jal_valid_E", obs[0].valid_e, 1);
        apply_stimulus(I_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        check("stall1_valid_E", obs[0].valid_e, 1);
        check("stall1_valid_M", obs[0].valid_m, 0);
        apply_stimulus(I_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        check("stall2_valid_E", obs[0].valid_e, 1);
        check("stall2_valid_M", obs[0].valid_m, 0);
        check("stall2_valid_W", obs[0].valid_w, 0);
        apply_stimulus(I_ADD, 1'b1, 1'b1, 1'b1, 1'b1);
        check("flush_valid_E", obs[0].valid_e, 0);
        check("flush_valid_M", obs[0].valid_m, 1);
        bubbles(1);
        check("jal_valid_W", obs[0].valid_w, 1);
        check("jal_regsrc_W", obs[0].regsrc_w, 2);
        bubbles(3);
        check("jal_instret_a", obs[0].instret, 5);
        check("jal_instret_b", obs[1].instret, 6);

        apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) apply_stimulus(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        bubbles(4);
        check("wrap_instret_a", obs[0].instret, 17);
        check("wrap_instret_b", obs[1].instret, 1);

        for (int i = 0; i < 600; i++)
            apply_stimulus(rand_instr(), $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
                           $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
